mix_columns: RTL

Applies the AES MixColumns transformation, or InvMixColumns when `INVERSE=1`, to a 128-bit state block. It works on one column per clock cycle. The block sits in the round datapath directly downstream of the sub-bytes / shift-rows stage. That stage's `valid_out` drives this block's `new_block_in`, and this block's output feeds add-round-key. It uses the same one-shot `new_block_in` / `valid_out` handshake as its neighbours.

---
 rtl/mix_columns.sv | 100 ++++++++++
 1 files changed

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - AES MixColumns / InvMixColumns, one column per clock.
module mix_columns #(
  parameter bit INVERSE = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             new_block_in,
  input  logic [15:0][7:0] block_in,
  output logic [15:0][7:0] mixed_block_out,
  output logic             valid_out,
  output logic             busy_out
);

  typedef enum logic [1:0] {IDLE, MIX, OUTPUT} state_t;

  // coef[k] multiplies the byte k rows below the output row (mod 4).
  localparam logic [3:0][3:0] COEF = INVERSE ? {4'h9, 4'hd, 4'hb, 4'he}
                                             : {4'h1, 4'h1, 4'h3, 4'h2};

  state_t           state, state_next;
  logic [1:0]       col;
  logic [15:0][7:0] saved_block;
  logic [15:0][7:0] result;
  logic [3:0][7:0]  col_in;
  logic [3:0][7:0]  col_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      col_in[i] = saved_block[{col, 2'(i)}];
    end
    for (int r = 0; r < 4; r++) begin
      col_mixed[r] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        col_mixed[r] = col_mixed[r] ^ gmul(col_in[j], COEF[2'(j - r)]);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      col             <= 2'd0;
      saved_block     <= '0;
      result          <= '0;
      mixed_block_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (new_block_in) begin
            saved_block <= block_in;
            col         <= 2'd0;
            result      <= '0;
          end
        end
        MIX: begin
          for (int i = 0; i < 4; i++) begin
            result[{col, 2'(i)}] <= col_mixed[i];
          end
          col <= col + 2'd1;
        end
        OUTPUT: begin
          mixed_block_out <= result;
          valid_out       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (new_block_in) state_next = MIX;
      MIX:     if (col == 2'd3) state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state != IDLE);
  end

endmodule
